lsu_dmem_master: RTL and testbench

Initiator side of the data-memory port: sits in the MEM stage between the pipeline's load/store request and the word-only data RAM (registered read, 1-cycle latency, no byte enables). Translates RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW into word reads and writes. Performs byte-lane extraction with sign or zero extension on loads. Sub-word stores use read-modify-write. Returns one response per accepted request and exposes `busy` as the pipeline stall.

---
 rtl/lsu_dmem_master_pkg.sv | 33 +++
 rtl/lsu_dmem_master_if.sv | 35 +++
 rtl/lsu_dmem_master_lane_align.sv | 39 +++
 rtl/lsu_dmem_master.sv | 138 +++++++++++++
 tb/tb_lsu_dmem_master.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_dmem_master_pkg.sv
// Shared definitions for the load/store data-memory master: RISC-V width
// encodings, FSM state type and the alignment check used at request accept.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_RMW_MERGE = 2'd2
    } lsu_state_e;

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return (addr_lo != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic illegal_funct3(input logic [2:0] funct3, input logic we);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b0;
            F3_BU, F3_HU:     return we;
            default:          return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_dmem_master_if.sv
// Bundle of the pipeline request/response handshake and the word RAM port.
// The master modport is the LSU view; slave is the pipeline + RAM environment.
interface lsu_dmem_master_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    logic        mem_wen;
    logic        mem_ren;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy,
        output mem_wen, mem_ren, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy,
        input  mem_wen, mem_ren, mem_addr, mem_wdata
    );

endinterface

// File: rtl/lsu_dmem_master_lane_align.sv
// Byte-lane steering: load-side extract/extend from a RAM word and
// store-side merge of a byte or half into the old word (little-endian).
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] old_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
        half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_o = {24'h0, byte_sel};
            F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_o = {16'h0, half_sel};
            default: load_o = rdata_i;
        endcase

        merge_o = old_i;
        if (funct3_i == F3_B) begin
            merge_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
        end else if (funct3_i == F3_H) begin
            if (offset_i[1]) merge_o[31:16] = wdata_i;
            else             merge_o[15:0]  = wdata_i;
        end
    end

endmodule

// File: rtl/lsu_dmem_master.sv
// MEM-stage data-memory master: turns RISC-V loads/stores into word RAM
// accesses, with read-modify-write for SB/SH and registered responses.
module lsu_dmem_master
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                clk,
    input  logic                rst,
    lsu_dmem_master_if.master   bus
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  f3_q, f3_d;
    logic [15:0] wdata_q, wdata_d;

    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        req_ready;
    logic        accept;
    logic        req_err;
    logic        out_of_range;
    logic        mem_wen, mem_ren;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] load_data, merge_data;

    lsu_lane_align u_align (
        .rdata_i  (bus.mem_rdata),
        .offset_i (addr_q[1:0]),
        .funct3_i (f3_q),
        .old_i    (bus.mem_rdata),
        .wdata_i  (wdata_q),
        .load_o   (load_data),
        .merge_o  (merge_data)
    );

    assign req_ready    = (state_q == ST_IDLE) && !rst;
    assign accept       = bus.req_valid && req_ready;
    assign out_of_range = ({2'b00, bus.req_addr[31:2]} >= DEPTH_WORDS);
    assign req_err      = misaligned(bus.req_funct3, bus.req_addr[1:0])
                        || illegal_funct3(bus.req_funct3, bus.req_we)
                        || out_of_range;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        f3_d         = f3_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        mem_wen      = 1'b0;
        mem_ren      = 1'b0;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;

        // Reset silences the RAM port so a pending RMW write is dropped.
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    mem_addr = {bus.req_addr[31:2], 2'b00};
                    if (accept) begin
                        if (req_err) begin
                            resp_valid_d = 1'b1;
                            resp_err_d   = 1'b1;
                        end else begin
                            addr_d  = bus.req_addr;
                            f3_d    = bus.req_funct3;
                            wdata_d = bus.req_wdata[15:0];
                            if (!bus.req_we) begin
                                mem_ren = 1'b1;
                                state_d = ST_LOAD_WAIT;
                            end else if (bus.req_funct3 == F3_W) begin
                                mem_wen      = 1'b1;
                                mem_wdata    = bus.req_wdata;
                                resp_valid_d = 1'b1;
                            end else begin
                                mem_ren = 1'b1;
                                state_d = ST_RMW_MERGE;
                            end
                        end
                    end
                end
                ST_LOAD_WAIT: begin
                    mem_addr     = {addr_q[31:2], 2'b00};
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                    state_d      = ST_IDLE;
                end
                ST_RMW_MERGE: begin
                    mem_wen      = 1'b1;
                    mem_addr     = {addr_q[31:2], 2'b00};
                    mem_wdata    = merge_data;
                    resp_valid_d = 1'b1;
                    state_d      = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Saved request fields are only consumed after a clean accept.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        f3_q    <= f3_d;
        wdata_q <= wdata_d;
    end

    assign bus.req_ready  = req_ready;
    assign bus.busy       = !req_ready && !rst;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_wen    = mem_wen;
    assign bus.mem_ren    = mem_ren;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed bench for lsu_dmem_master with a registered-read word RAM model.
module tb_lsu_dmem_master;
    import lsu_pkg::*;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    lsu_dmem_master_if bus ();

    lsu_dmem_master #(.DEPTH_WORDS(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] ram [0:1023];
    logic        pre_we;
    logic [9:0]  pre_idx;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) ram[pre_idx] <= pre_data;
        if (bus.mem_wen) ram[bus.mem_addr[11:2]] <= bus.mem_wdata;
        if (bus.mem_ren) bus.mem_rdata <= ram[bus.mem_addr[11:2]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
    endtask

    task automatic idle_req();
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
    endtask

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = idx; pre_data = data;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        send(1'b0, F3_W, 32'h10, 32'h0);
        repeat (2) @(negedge clk);
        tests++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", bus.req_ready); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        tests++; if ({bus.resp_valid, bus.resp_err} !== 2'b00) begin fails++; $display("FAIL rst_resp: got %b want 00", {bus.resp_valid, bus.resp_err}); end
        tests++; if (bus.resp_rdata !== 32'h0) begin fails++; $display("FAIL rst_rdata: got %h want 0", bus.resp_rdata); end
        tests++; if ({bus.mem_ren, bus.mem_wen} !== 2'b00) begin fails++; $display("FAIL rst_mem_en: got %b want 00", {bus.mem_ren, bus.mem_wen}); end
        tests++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin fails++; $display("FAIL rst_mem_bus: got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata); end
        idle_req();
        rst = 1'b0;
        #1;
        tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ready: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [5];
        logic [31:0] adr [5];
        logic [31:0] exp [5];
        f3s = '{F3_B, F3_BU, F3_H, F3_HU, F3_W};
        adr = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10};
        exp = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h0000AABB, 32'h8899AABB};
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL load%0d_ready: got %b want 1", i, bus.req_ready); end
            send(1'b0, f3s[i], adr[i], 32'h0);
            #1;
            tests++; if (bus.mem_ren !== 1'b1 || bus.mem_wen !== 1'b0 || bus.mem_addr !== 32'h10) begin
                fails++; $display("FAIL load%0d_issue: got ren=%b wen=%b addr=%h want 1 0 00000010", i, bus.mem_ren, bus.mem_wen, bus.mem_addr); end
            @(negedge clk);
            idle_req();
            tests++; if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b1) begin
                fails++; $display("FAIL load%0d_t1: got valid=%b busy=%b want 0 1", i, bus.resp_valid, bus.busy); end
            @(negedge clk);
            tests++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.resp_rdata !== exp[i]) begin
                fails++; $display("FAIL load%0d_data: got v=%b e=%b %h want 1 0 %h", i, bus.resp_valid, bus.resp_err, bus.resp_rdata, exp[i]); end
        end
    endtask

    task automatic test_rmw();
        logic [2:0]  f3s [2];
        logic [31:0] adr [2];
        logic [31:0] wds [2];
        logic [31:0] exp [2];
        f3s = '{F3_B, F3_H};
        adr = '{32'h21, 32'h22};
        wds = '{32'hFFFFFFA5, 32'h0000BEEF};
        exp = '{32'h1122A544, 32'hBEEFA544};
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            send(1'b1, f3s[i], adr[i], wds[i]);
            #1;
            tests++; if (bus.mem_ren !== 1'b1 || bus.mem_wen !== 1'b0) begin
                fails++; $display("FAIL rmw%0d_read: got ren=%b wen=%b want 1 0", i, bus.mem_ren, bus.mem_wen); end
            @(negedge clk);
            idle_req();
            tests++; if (bus.mem_wen !== 1'b1 || bus.mem_ren !== 1'b0 || bus.mem_addr !== 32'h20 || bus.mem_wdata !== exp[i]) begin
                fails++; $display("FAIL rmw%0d_write: got wen=%b ren=%b %h=%h want 1 0 00000020=%h", i, bus.mem_wen, bus.mem_ren, bus.mem_addr, bus.mem_wdata, exp[i]); end
            @(negedge clk);
            tests++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'h0) begin
                fails++; $display("FAIL rmw%0d_resp: got v=%b e=%b %h want 1 0 0", i, bus.resp_valid, bus.resp_err, bus.resp_rdata); end
            tests++; if (ram[8] !== exp[i]) begin fails++; $display("FAIL rmw%0d_ram: got %h want %h", i, ram[8], exp[i]); end
        end
    endtask

    task automatic test_sw_then_lw();
        @(negedge clk);
        send(1'b1, F3_W, 32'h40, 32'hDEADBEEF);
        #1;
        tests++; if (bus.mem_wen !== 1'b1 || bus.mem_ren !== 1'b0 || bus.mem_addr !== 32'h40 || bus.mem_wdata !== 32'hDEADBEEF) begin
            fails++; $display("FAIL sw_issue: got wen=%b ren=%b %h=%h want 1 0 00000040=deadbeef", bus.mem_wen, bus.mem_ren, bus.mem_addr, bus.mem_wdata); end
        @(negedge clk);
        tests++; if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b1) begin
            fails++; $display("FAIL sw_ack: got v=%b ready=%b want 1 1", bus.resp_valid, bus.req_ready); end
        send(1'b0, F3_W, 32'h40, 32'h0);
        @(negedge clk);
        idle_req();
        tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL lw_t1: got %b want 0", bus.resp_valid); end
        @(negedge clk);
        tests++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hDEADBEEF) begin
            fails++; $display("FAIL lw_after_sw: got v=%b %h want 1 deadbeef", bus.resp_valid, bus.resp_rdata); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            send(1'b1, F3_W, 32'(4 * i), 32'hC0DE_0000 + 32'(i));
            @(negedge clk);
            if (bus.resp_valid === 1'b1) pulses++;
        end
        idle_req();
        repeat (2) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) pulses++;
        end
        tests++; if (pulses != 3) begin fails++; $display("FAIL sw_burst_pulses: got %0d want 3", pulses); end
        for (int i = 0; i < 3; i++) begin
            tests++; if (ram[i] !== 32'hC0DE_0000 + 32'(i)) begin
                fails++; $display("FAIL sw_burst_ram%0d: got %h want %h", i, ram[i], 32'hC0DE_0000 + 32'(i)); end
        end
    endtask

    task automatic test_errors();
        logic        wes [5];
        logic [2:0]  f3s [5];
        logic [31:0] adr [5];
        wes = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        f3s = '{F3_H, F3_W, 3'b011, 3'b100, F3_W};
        adr = '{32'h11, 32'h42, 32'h10, 32'h30, 32'd4096};
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            send(wes[i], f3s[i], adr[i], 32'h12345678);
            #1;
            tests++; if (bus.mem_ren !== 1'b0 || bus.mem_wen !== 1'b0) begin
                fails++; $display("FAIL err%0d_noaccess: got ren=%b wen=%b want 0 0", i, bus.mem_ren, bus.mem_wen); end
            @(negedge clk);
            idle_req();
            tests++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_rdata !== 32'h0 || bus.req_ready !== 1'b1) begin
                fails++; $display("FAIL err%0d_resp: got v=%b e=%b %h ready=%b want 1 1 0 1", i, bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.req_ready); end
        end
    endtask

    task automatic test_reset_mid_rmw();
        @(negedge clk);
        send(1'b1, F3_B, 32'h30, 32'h000000AA);
        @(negedge clk);
        idle_req();
        rst = 1'b1;
        #1;
        tests++; if (bus.mem_wen !== 1'b0 || bus.req_ready !== 1'b0 || bus.busy !== 1'b0) begin
            fails++; $display("FAIL rstmid_outputs: got wen=%b ready=%b busy=%b want 0 0 0", bus.mem_wen, bus.req_ready, bus.busy); end
        @(negedge clk);
        tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL rstmid_resp: got %b want 0", bus.resp_valid); end
        rst = 1'b0;
        #1;
        tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready: got %b want 1", bus.req_ready); end
        tests++; if (ram[12] !== 32'h55667788) begin fails++; $display("FAIL rstmid_ram: got %h want 55667788", ram[12]); end
        @(negedge clk);
        tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL rstmid_late_resp: got %b want 0", bus.resp_valid); end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rst    = 1'b1;
        pre_we = 1'b0;
        pre_idx = 10'h0;
        pre_data = 32'h0;
        idle_req();
        preload(10'd4, 32'h8899AABB);
        preload(10'd8, 32'h11223344);
        preload(10'd12, 32'h55667788);
        test_reset();
        test_loads();
        test_rmw();
        test_sw_then_lw();
        test_back_to_back();
        test_errors();
        test_reset_mid_rmw();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
